// File: rtl/fir_pkg.sv
// Shared FIR definitions: core operation codes, sequencer states and default widths.
// The core and the stream sequencer both import this package.
package fir_pkg;

  typedef enum logic [1:0] {
    OP_IDLE    = 2'b00,
    OP_LOAD    = 2'b01,
    OP_COMPUTE = 2'b10,
    OP_READ    = 2'b11
  } fir_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMPUTE,
    ST_READ,
    ST_READ_WAIT
  } fir_state_t;

  localparam int FIR_SIGNAL_COUNT = 10;
  localparam int FIR_DATA_W       = 32;
  localparam int FIR_ADDR_W       = 32;
  localparam int FIR_READ_LAT     = 1;
  localparam int LAT_W            = 3;

  // Core operation presented while the sequencer sits in a given state.
  function automatic fir_op_t op_of_state(fir_state_t s);
    case (s)
      ST_LOAD:                return OP_LOAD;
      ST_COMPUTE:             return OP_COMPUTE;
      ST_READ, ST_READ_WAIT:  return OP_READ;
      default:                return OP_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/fir_lat_counter.sv
// Loadable down-counter timing the core read latency; tc flags the terminal count of zero.
module fir_lat_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (en && (cnt != '0))
      cnt <= cnt - W'(1);
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/fir_stream_sequencer.sv
// Stream-side sequencer for the FIR core: loads a frame of samples, waits for compute,
// then reads results back onto a valid/ready output stream.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// ST_IDLE      | ready for the first sample of a frame
// ST_LOAD      | presenting samples to the core, one address per handshake
// ST_COMPUTE   | core computing, waiting for done
// ST_READ_WAIT | result address driven, waiting READ_LAT cycles for y
// ST_READ      | result held on m_data until the downstream accepts it
module fir_stream_sequencer
  import fir_pkg::*;
#(
  parameter int SIGNAL_COUNT = FIR_SIGNAL_COUNT,
  parameter int DATA_W       = FIR_DATA_W,
  parameter int ADDR_W       = FIR_ADDR_W,
  parameter int READ_LAT     = FIR_READ_LAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic [1:0]        operation,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] x,
  input  logic              done,
  input  logic [DATA_W-1:0] y,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              frame_done
);

  localparam int               IDX_W    = (SIGNAL_COUNT > 1) ? $clog2(SIGNAL_COUNT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIGNAL_COUNT - 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LAT - 1);

  fir_state_t        state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [DATA_W-1:0] x_nxt, m_data_nxt;
  logic              s_ready_nxt, m_valid_nxt, frame_done_nxt;
  logic              lat_load, lat_en, lat_tc;
  logic              s_hs, m_hs;

  assign s_hs = s_valid && s_ready;
  assign m_hs = m_valid && m_ready;
  assign addr = ADDR_W'(idx);

  fir_lat_counter #(.W(LAT_W)) u_lat (
    .clk      (clk),
    .reset    (reset),
    .load     (lat_load),
    .load_val (LAT_LOAD),
    .en       (lat_en),
    .tc       (lat_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      operation  <= OP_IDLE;
      idx        <= '0;
      x          <= '0;
      s_ready    <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      operation  <= op_of_state(state_nxt);
      idx        <= idx_nxt;
      x          <= x_nxt;
      s_ready    <= s_ready_nxt;
      m_valid    <= m_valid_nxt;
      m_data     <= m_data_nxt;
      frame_done <= frame_done_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    x_nxt          = x;
    m_data_nxt     = m_data;
    s_ready_nxt    = s_ready;
    m_valid_nxt    = m_valid;
    frame_done_nxt = 1'b0;
    lat_load       = 1'b0;
    lat_en         = 1'b0;

    unique case (state)
      ST_IDLE: begin
        s_ready_nxt = 1'b1;
        if (s_hs) begin
          x_nxt       = s_data;
          idx_nxt     = '0;
          state_nxt   = ST_LOAD;
          s_ready_nxt = (LAST_IDX != '0);
        end
      end

      ST_LOAD: begin
        // Ready drops on the handshake that accepts the last sample, so it is never over-consumed.
        if (idx == LAST_IDX) begin
          s_ready_nxt = 1'b0;
          state_nxt   = ST_COMPUTE;
        end else if (s_hs) begin
          x_nxt   = s_data;
          idx_nxt = idx + 1'b1;
          if (idx_nxt == LAST_IDX)
            s_ready_nxt = 1'b0;
        end
      end

      ST_COMPUTE: begin
        if (done) begin
          idx_nxt   = '0;
          lat_load  = 1'b1;
          state_nxt = ST_READ_WAIT;
        end
      end

      ST_READ_WAIT: begin
        if (lat_tc) begin
          m_data_nxt  = y;
          m_valid_nxt = 1'b1;
          state_nxt   = ST_READ;
        end else begin
          lat_en = 1'b1;
        end
      end

      ST_READ: begin
        if (m_hs) begin
          m_valid_nxt = 1'b0;
          if (idx == LAST_IDX) begin
            idx_nxt        = '0;
            frame_done_nxt = 1'b1;
            s_ready_nxt    = 1'b1;
            state_nxt      = ST_IDLE;
          end else begin
            idx_nxt   = idx + 1'b1;
            lat_load  = 1'b1;
            state_nxt = ST_READ_WAIT;
          end
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fir_stream_sequencer.sv
// Self-checking bench for fir_stream_sequencer with a behavioural FIR core (y = 2*addr, 3-cycle read).
module tb_fir_stream_sequencer;

  localparam int N   = 10;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          reset, s_valid, s_ready, done, m_valid, m_ready, frame_done;
  logic [DW-1:0] s_data, x, y, m_data;
  logic [AW-1:0] addr;
  logic [1:0]    operation;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;
  int            done_delay = 0;
  logic          done_force = 1'b0;
  int            ccnt = 0;
  logic [31:0]   exp_q[$];
  logic [63:0]   wr_log[$];
  logic [AW-1:0] a_d1 = '0, a_d2 = '0;
  bit            stall_prev = 1'b0;
  logic [31:0]   stall_data = '0;

  always #5 clk = ~clk;

  fir_stream_sequencer #(
    .SIGNAL_COUNT (N),
    .DATA_W       (DW),
    .ADDR_W       (AW),
    .READ_LAT     (LAT)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .operation  (operation),
    .addr       (addr),
    .x          (x),
    .done       (done),
    .y          (y),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .frame_done (frame_done)
  );

  // Core model: two address pipeline stages plus the sampling edge give a 3-cycle read.
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    a_d1 <= addr;
    a_d2 <= a_d1;
    ccnt <= (operation == 2'b10) ? ccnt + 1 : 0;
    if (operation == 2'b01)
      if (wr_log.size() == 0 || wr_log[$] != {addr, x})
        wr_log.push_back({addr, x});
  end
  assign y    = a_d2 << 1;
  assign done = done_force || (operation == 2'b10 && ccnt >= done_delay);

  // Output scoreboard and stall-stability monitor.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (stall_prev) begin
        n_tests++;
        if (m_valid !== 1'b1 || m_data !== stall_data) begin
          n_fail++;
          $display("FAIL stall_hold: m_valid=%0b m_data=%0d required 1 and %0d", m_valid, m_data, stall_data);
        end
      end
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL result_dup: m_data=%0d with no expected result pending", m_data);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (m_data !== e) begin
            n_fail++;
            $display("FAIL result: m_data=%0d required %0d", m_data, e);
          end
        end
      end
    end
    stall_prev = (reset === 1'b0) && (m_valid === 1'b1) && (m_ready === 1'b0);
    stall_data = m_data;
  end

  task automatic send_frame(input int base, input int n, input int gap_a, input int gap_b,
                            input int gap_len, output int first_cyc);
    int g;
    first_cyc = -1;
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = 32'(base + i);
      g = 0;
      while (s_ready !== 1'b1 && g < 200) begin
        @(posedge clk); #1; g++;
      end
      if (s_ready !== 1'b1) begin
        n_tests++; n_fail++;
        $display("FAIL s_ready_timeout: s_ready=%0b required 1 at sample %0d", s_ready, i);
        s_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      if (i == 0) first_cyc = cyc;
      exp_q.push_back(32'(2 * i));
      n_tests++;
      if (addr !== 32'(i) || x !== 32'(base + i) || operation !== 2'b01) begin
        n_fail++;
        $display("FAIL load_step: addr=%0d x=%0d op=%0d required %0d %0d 1", addr, x, operation, i, base + i);
      end
      if (i == gap_a || i == gap_b) begin
        s_valid = 1'b0;
        repeat (gap_len) begin
          @(posedge clk); #1;
          n_tests++;
          if (addr !== 32'(i) || x !== 32'(base + i)) begin
            n_fail++;
            $display("FAIL gap_hold: addr=%0d x=%0d required %0d %0d", addr, x, i, base + i);
          end
        end
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_op(input logic [1:0] op, output int k);
    k = 0;
    while (operation !== op && k < 500) begin
      @(posedge clk); #1; k++;
    end
    n_tests++;
    if (operation !== op) begin
      n_fail++;
      $display("FAIL wait_op: operation=%0d required %0d", operation, op);
    end
  endtask

  task automatic collect(input bit rnd, output int cycles);
    cycles = 0;
    while (cycles < 3000) begin
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      cycles++;
      if (frame_done === 1'b1) break;
    end
    m_ready = 1'b0;
    n_tests++;
    if (frame_done !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_done_timeout: frame_done=%0b required 1", frame_done);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL result_lost: %0d results pending, required 0", exp_q.size());
    end
  endtask

  task automatic check_reset_values(input string tag);
    n_tests++;
    if (operation !== 2'b00 || addr !== '0 || x !== '0 || s_ready !== 1'b0 ||
        m_valid !== 1'b0 || m_data !== '0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: op=%0d addr=%0d x=%0d s_ready=%0b m_valid=%0b m_data=%0d frame_done=%0b required all zero",
               tag, operation, addr, x, s_ready, m_valid, m_data, frame_done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; s_valid = 1'b1; s_data = 32'd55; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset_values");
    reset = 1'b0; s_valid = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (s_ready !== 1'b1 || operation !== 2'b00 || addr !== '0) begin
      n_fail++;
      $display("FAIL idle_after_reset: s_ready=%0b op=%0d addr=%0d required 1 0 0", s_ready, operation, addr);
    end
  endtask

  task automatic test_stream();
    int fc, k, lat, cycles;
    done_delay = 0;
    send_frame(1, N, -1, -1, 0, fc);
    n_tests++;
    if (s_ready !== 1'b0 || operation !== 2'b01 || addr !== 32'(N - 1)) begin
      n_fail++;
      $display("FAIL last_sample: s_ready=%0b op=%0d addr=%0d required 0 1 %0d", s_ready, operation, addr, N - 1);
    end
    @(posedge clk); #1;
    n_tests++;
    if (operation !== 2'b10) begin
      n_fail++;
      $display("FAIL to_compute: operation=%0d required 2", operation);
    end
    wait_op(2'b11, k);
    n_tests++;
    if (addr !== '0 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL read_start: addr=%0d m_valid=%0b required 0 0", addr, m_valid);
    end
    lat = 0;
    while (m_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    n_tests++;
    if (lat != LAT) begin
      n_fail++;
      $display("FAIL read_latency: %0d cycles required %0d", lat, LAT);
    end
    collect(1'b0, cycles);
    n_tests++;
    if (cycles != (N - 1) * (LAT + 1) + 1) begin
      n_fail++;
      $display("FAIL result_period: %0d cycles required %0d", cycles, (N - 1) * (LAT + 1) + 1);
    end
    n_tests++;
    if (operation !== 2'b00 || addr !== '0 || s_ready !== 1'b1 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_end: op=%0d addr=%0d s_ready=%0b m_valid=%0b required 0 0 1 0",
               operation, addr, s_ready, m_valid);
    end
    @(posedge clk); #1;
    n_tests++;
    if (frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_done_pulse: frame_done=%0b required 0", frame_done);
    end
  endtask

  task automatic test_gaps();
    int fc, k, cycles;
    done_delay = 0;
    wr_log.delete();
    done_force = 1'b1;
    send_frame(1, N, 2, 6, 4, fc);
    done_force = 1'b0;
    wait_op(2'b11, k);
    collect(1'b0, cycles);
    n_tests++;
    if (wr_log.size() != N) begin
      n_fail++;
      $display("FAIL core_writes: %0d distinct writes required %0d", wr_log.size(), N);
    end else begin
      for (int i = 0; i < N; i++) begin
        n_tests++;
        if (wr_log[i] !== {32'(i), 32'(i + 1)}) begin
          n_fail++;
          $display("FAIL core_write: entry %0d addr=%0d x=%0d required %0d %0d",
                   i, wr_log[i][63:32], wr_log[i][31:0], i, i + 1);
        end
      end
    end
  endtask

  task automatic test_done_delay();
    int fc, k, cycles, n10, bad;
    done_delay = 50;
    send_frame(100, N, -1, -1, 0, fc);
    s_valid = 1'b1; s_data = 32'd77;
    @(posedge clk); #1;
    n10 = 0; bad = 0; k = 0;
    while (operation === 2'b10 && k < 200) begin
      n10++;
      if (s_ready !== 1'b0) bad++;
      @(posedge clk); #1; k++;
    end
    s_valid = 1'b0;
    n_tests++;
    if (n10 != done_delay + 1 || bad != 0) begin
      n_fail++;
      $display("FAIL compute_hold: %0d compute cycles, %0d with s_ready high, required %0d and 0", n10, bad, done_delay + 1);
    end
    n_tests++;
    if (operation !== 2'b11 || x !== 32'(100 + N - 1)) begin
      n_fail++;
      $display("FAIL compute_exit: op=%0d x=%0d required 3 %0d", operation, x, 100 + N - 1);
    end
    collect(1'b0, cycles);
    done_delay = 0;
  endtask

  task automatic test_backpressure();
    int fc, k, cycles;
    send_frame(200, N, -1, -1, 0, fc);
    wait_op(2'b11, k);
    collect(1'b1, cycles);
  endtask

  task automatic test_mid_reset();
    int fc, k, cycles;
    send_frame(300, 6, -1, -1, 0, fc);
    s_valid = 1'b1; s_data = 32'd999;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; s_valid = 1'b0;
    exp_q.delete();
    check_reset_values("mid_load_reset");
    send_frame(400, N, -1, -1, 0, fc);
    wait_op(2'b11, k);
    collect(1'b0, cycles);
  endtask

  task automatic test_back_to_back();
    int fc, k, cycles, fd_cyc;
    send_frame(500, N, -1, -1, 0, fc);
    wait_op(2'b11, k);
    collect(1'b0, cycles);
    fd_cyc = cyc;
    n_tests++;
    if (s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready: s_ready=%0b required 1 with frame_done", s_ready);
    end
    send_frame(600, N, -1, -1, 0, fc);
    n_tests++;
    if (fc != fd_cyc + 1) begin
      n_fail++;
      $display("FAIL b2b_accept: first sample at cycle %0d required %0d", fc, fd_cyc + 1);
    end
    wait_op(2'b11, k);
    collect(1'b0, cycles);
  endtask

  initial begin
    reset = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    test_reset();
    test_stream();
    test_gaps();
    test_done_delay();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

endmodule

// File: doc/fir_stream_sequencer.md
# fir_stream_sequencer

Stream-side controller that sits directly upstream and downstream of the FIR core (`fir_srg` or `fir_rns` behind its converters).
- Accepts a frame of input samples over a valid/ready stream and drives them into the core with the core's `operation`/`addr`/`x` protocol.
- Holds the core in compute until `done`, then walks the core's result addresses and returns results on a valid/ready output stream.
- Replaces the hard-coded ROM-driven sequencing in the top level, so frames can come from any producer.

## Interface
Parameters:
- `SIGNAL_COUNT`, 10: samples per frame, and results read back per frame.
- `DATA_W`, 32: sample and result width.
- `ADDR_W`, 32: width of the core's `addr` port.
- `READ_LAT`, 1: cycles from `addr` change to valid `y`. Range 1..4.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `s_valid`  in  1  input sample valid.
- `s_data`  in  DATA_W  input sample.
- `s_ready`  out  1  sequencer accepts a sample.
- `operation`  out  2  to core: 00 idle, 01 load, 10 compute, 11 read.
- `addr`  out  ADDR_W  to core: sample index or result index.
- `x`  out  DATA_W  to core: sample value.
- `done`  in  1  from core: compute finished.
- `y`  in  DATA_W  from core: result at `addr`.
- `m_valid`  out  1  result valid.
- `m_data`  out  DATA_W  result value.
- `m_ready`  in  1  downstream accepts a result.
- `frame_done`  out  1  one-cycle pulse after the last result is accepted.

## Operation
- States: IDLE, LOAD, COMPUTE, READ, READ_WAIT. `operation` is a registered function of state: IDLE=00, LOAD=01, COMPUTE=10, READ/READ_WAIT=11.
- Reset values: state IDLE, `operation`=00, `addr`=0, `x`=0, `s_ready`=0, `m_valid`=0, `m_data`=0, `frame_done`=0. Reset in any state aborts the frame; partial data is discarded.
- IDLE: `s_ready`=1. Handshake (`s_valid`&&`s_ready`) sets `x`<=`s_data`, `addr`<=0, goes to LOAD.
- LOAD: `s_ready`=1 while fewer than SIGNAL_COUNT samples are accepted.
  - Each handshake sets `x`<=`s_data`, `addr`<=`addr`+1.
  - With no handshake, `addr` and `x` hold. The core treats a repeated (addr, x) write as idempotent.
  - The edge after the sample at `addr`=SIGNAL_COUNT-1 has been presented: `s_ready`<=0, go to COMPUTE.
- COMPUTE: `s_ready`=0. Wait for `done`=1, then `addr`<=0 and go to READ_WAIT. `done` is ignored in IDLE and LOAD.
- READ_WAIT: latency counter runs READ_LAT cycles, then `m_data`<=`y`, `m_valid`<=1, go to READ.
- READ: hold `m_valid`/`m_data` stable until `m_ready`.
  - On handshake at any `addr` other than the last: `m_valid`<=0, `addr`<=`addr`+1, go to READ_WAIT.
  - On handshake at `addr`=SIGNAL_COUNT-1: `m_valid`<=0, `addr`<=0, `operation`<=00, `frame_done`<=1, go to IDLE.
- Widths:
  - `addr` counts 0..SIGNAL_COUNT-1 and never wraps mid-frame. It is zero-extended to ADDR_W.
  - `x`, `m_data` and `y` pass through unmodified; the sequencer does no arithmetic on data.
- `s_valid` while `s_ready`=0 is ignored; the sample is not consumed.

## Timing
- First handshake at edge E: `operation`=01, `addr`=0, `x`=sample0 visible after E.
- With `s_valid` held high, one sample is accepted per cycle. `operation`=10 appears one edge after the last sample is presented.
- `done` sampled high at edge D: `operation`=11, `addr`=0 after D.
- `m_valid` rises READ_LAT edges after each `addr` update.
- With `m_ready` held high, result period is READ_LAT+1 cycles.
- `frame_done` pulses on the edge the last result handshake is registered. IDLE accepts a new sample on the following cycle.
- Simultaneous `reset` and any handshake: reset wins and the handshake is not consumed.

## Structure
- Shared package `fir_pkg` holds:
  - the `fir_op_t` enum (OP_IDLE=2'b00, OP_LOAD=2'b01, OP_COMPUTE=2'b10, OP_READ=2'b11);
  - the state enum;
  - default widths.
  The core and the top level import the same enum.
- One sub-module: `fir_lat_counter`, a loadable down-counter for the READ_WAIT delay. Everything else is in a single FSM.

## Test plan
- Reset, then stream samples 1..10 with `s_valid` always high; core model returns `y`=2·addr. Required: `operation` 01→10→11, `m_data` sequence 0,2,…,18, `frame_done` after the 10th handshake.
- Insert `s_valid` gaps after samples 3 and 7. Required: `addr`/`x` hold during gaps; the core receives exactly samples 1..10 at `addr` 0..9.
- Delay `done` by 50 cycles. Required: `operation` stays 10 and `s_ready`=0 throughout.
- Random `m_ready` backpressure with READ_LAT=3. Required: `m_data` stable while `m_valid`&&!`m_ready`; no result lost or duplicated.
- Assert `reset` for one cycle in mid-LOAD, at `addr`=5. Required: all outputs return to reset values; the next frame starts at `addr`=0.
- Send two frames back-to-back. Required: the first sample of the second frame is accepted on the cycle after `frame_done`.
